// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store sequencer between the CPU data port and the MMU / system bus.
//   One request in flight at a time: IDLE -> XLATE -> BUS -> RESP.
//   Misaligned requests bypass the MMU and answer one cycle after accept.
//   MMU exceptions answer without touching the bus.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined:   BUS gives up after TIMEOUT_CYCLES cycles without bus_ack and
//              responds with resp_buserr=1.
//   Undefined: BUS waits indefinitely, resp_buserr is tied low.
//
// Ports
//   clk, res             clock / async active-low reset
//   req_*                CPU request (valid/ready handshake, accepted in IDLE)
//   resp_*               one-cycle response strobe plus held result fields
//   mmu_addrValid/vAddr  MMU VA latch, driven combinationally in accept cycle
//   mmu_pAddr/db_io/exception  MMU result, valid the cycle after addrValid
//   bus_*                req/ack data bus; all outputs held stable until ack
// -----------------------------------------------------------------------------
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [1:0]
`endif
`ifndef MEM_ACCESS_W
`define MEM_ACCESS_W 2'd1
`endif
`ifndef MMU_EXCEPTION_T
`define MMU_EXCEPTION_T logic [2:0]
`endif
`ifndef MMU_EXCEPTION_NONE
`define MMU_EXCEPTION_NONE 3'd0
`endif
`ifndef MMU_EXCEPTION_TLBMISS
`define MMU_EXCEPTION_TLBMISS 3'd1
`endif

module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  res,
  // CPU request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_vaddr,
  input  `MEM_ACCESS_T          req_type,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  // CPU response
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output `MMU_EXCEPTION_T       resp_exc,
  output logic                  resp_misalign,
  output logic                  resp_buserr,
  // MMU
  output logic                  mmu_addrValid,
  output logic [31:0]           mmu_vAddr,
  input  logic [31:0]           mmu_pAddr,
  input  logic                  mmu_db_io,
  input  `MMU_EXCEPTION_T       mmu_exception,
  // system data bus
  output logic                  bus_req,
  output logic                  bus_we,
  output logic                  bus_io,
  output logic [31:0]           bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  typedef enum logic [1:0] {IDLE, XLATE, BUS, RESP} state_t;

  state_t       state;
  logic [1:0]   a_q;
  logic         we_q;
  logic [1:0]   size_q;
  logic [31:0]  wdata_q;

  logic         misalign;
  logic         accept;
  logic         tmo_hit;

  // Byte offset within the word only matters for the lane steering; the
  // bus address is word-aligned so the low pAddr bits are dropped.
  logic unused_paddr_lo;
  assign unused_paddr_lo = &{1'b0, mmu_pAddr[1:0]};

  // size 3 behaves as word, so size[1] alone selects the word case
  assign misalign = (req_size == 2'd1 && req_vaddr[0]) ||
                    (req_size[1] && req_vaddr[1:0] != 2'b00);

  assign accept        = req_valid && (state == IDLE);
  assign req_ready     = (state == IDLE);
  assign mmu_addrValid = accept && !misalign;
  assign mmu_vAddr     = req_vaddr;

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    be_f = 4'b0001 << a;
      2'd1:    be_f = a[1] ? 4'b1100 : 4'b0011;
      default: be_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_f(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    wd_f = {4{d[7:0]}};
      2'd1:    wd_f = {2{d[15:0]}};
      default: wd_f = d;
    endcase
  endfunction

  function automatic logic [31:0] rd_f(input logic [1:0] sz, input logic [1:0] a,
                                       input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (sz)
      2'd0:    rd_f = {24'b0, sh[7:0]};
      2'd1:    rd_f = {16'b0, sh[15:0]};
      default: rd_f = sh;
    endcase
  endfunction

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_W    = (TMO_CLOG < 8) ? 8 : ((TMO_CLOG > 32) ? 32 : TMO_CLOG);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             resp_load;

  // Counter holds at zero outside BUS, so it is clear on every BUS entry.
  always_ff @(posedge clk or negedge res) begin
    if (!res)                 tmo_cnt <= '0;
    else if (state != BUS)    tmo_cnt <= '0;
    else if (!bus_ack)        tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Expiry fires on the TIMEOUT_CYCLES-th ackless BUS cycle; an ack in that
  // same cycle takes priority.
  assign tmo_hit = (state == BUS) && !bus_ack && (tmo_cnt == TMO_LAST);

  // Every path into RESP rewrites buserr so a stale flag never leaks.
  assign resp_load = (accept && misalign) ||
                     (state == XLATE && mmu_exception != `MMU_EXCEPTION_NONE) ||
                     (state == BUS && (bus_ack || tmo_hit));

  always_ff @(posedge clk or negedge res) begin
    if (!res)           resp_buserr <= 1'b0;
    else if (resp_load) resp_buserr <= tmo_hit;
  end
`else
  assign tmo_hit     = 1'b0;
  assign resp_buserr = 1'b0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state         <= IDLE;
      a_q           <= '0;
      we_q          <= 1'b0;
      size_q        <= '0;
      wdata_q       <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= `MMU_EXCEPTION_NONE;
      resp_misalign <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_io        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= '0;
      bus_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_vaddr[1:0];
            we_q    <= (req_type == `MEM_ACCESS_W);
            size_q  <= req_size;
            wdata_q <= req_wdata;
            if (misalign) begin
              resp_valid    <= 1'b1;
              resp_rdata    <= '0;
              resp_exc      <= `MMU_EXCEPTION_NONE;
              resp_misalign <= 1'b1;
              state         <= RESP;
            end else begin
              state <= XLATE;
            end
          end
        end
        XLATE: begin
          if (mmu_exception != `MMU_EXCEPTION_NONE) begin
            resp_valid    <= 1'b1;
            resp_rdata    <= '0;
            resp_exc      <= mmu_exception;
            resp_misalign <= 1'b0;
            state         <= RESP;
          end else begin
            bus_addr  <= {mmu_pAddr[31:2], 2'b00};
            bus_io    <= mmu_db_io;
            bus_we    <= we_q;
            bus_be    <= be_f(size_q, a_q);
            bus_wdata <= wd_f(size_q, wdata_q);
            bus_req   <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          if (bus_ack || tmo_hit) begin
            bus_req       <= 1'b0;
            resp_valid    <= 1'b1;
            resp_rdata    <= (we_q || !bus_ack) ? 32'h0 : rd_f(size_q, a_q, bus_rdata);
            resp_exc      <= `MMU_EXCEPTION_NONE;
            resp_misalign <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [1:0]
`endif
`ifndef MEM_ACCESS_W
`define MEM_ACCESS_W 2'd1
`endif
`ifndef MMU_EXCEPTION_T
`define MMU_EXCEPTION_T logic [2:0]
`endif
`ifndef MMU_EXCEPTION_NONE
`define MMU_EXCEPTION_NONE 3'd0
`endif
`ifndef MMU_EXCEPTION_TLBMISS
`define MMU_EXCEPTION_TLBMISS 3'd1
`endif

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        res;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_type;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_exc;
  logic        resp_misalign;
  logic        resp_buserr;
  logic        mmu_addrValid;
  logic [31:0] mmu_vAddr;
  logic [31:0] mmu_pAddr;
  logic        mmu_db_io;
  logic [2:0]  mmu_exception;
  logic        bus_req, bus_we, bus_io;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_type(req_type), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_misalign(resp_misalign), .resp_buserr(resp_buserr),
    .mmu_addrValid(mmu_addrValid), .mmu_vAddr(mmu_vAddr), .mmu_pAddr(mmu_pAddr),
    .mmu_db_io(mmu_db_io), .mmu_exception(mmu_exception),
    .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // MMU/bus inputs carry junk whenever the DUT must not be looking at them.
  task automatic junk;
    mmu_pAddr     = $urandom;
    mmu_db_io     = 1'($urandom);
    mmu_exception = 3'($urandom);
    bus_rdata     = $urandom;
  endtask

  // Environment MMU: a fixed unmapped-segment style translation.
  function automatic logic [31:0] xlate(input logic [31:0] va);
    return va & 32'h1FFF_FFFF;
  endfunction

  // One complete transaction with the reference expectations derived from
  // byte-lane arithmetic: which bytes of the word the access touches.
  task automatic do_txn(input logic [31:0] va, input bit we, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [2:0] exc, input int waitc,
                        input logic [31:0] rd, input bit early_ack);
    int off, nb;
    bit mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    off = int'(va[1:0]);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (off % nb) != 0;
    e_be = '0; e_wd = '0; e_rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) e_be[i] = 1'b1;
      e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    if (!we && !mis)
      for (int i = 0; i < nb; i++) e_rd[8*i +: 8] = rd[8*(off + i) +: 8];

    // accept cycle
    req_valid = 1'b1;
    req_vaddr = va;
    req_size  = sz;
    req_wdata = wd;
    if (we) req_type = `MEM_ACCESS_W;
    else    req_type = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
    bus_ack = 1'b0;
    #1;
    chk("req_ready", 32'(req_ready), 32'd1);
    chk("mmu_addrValid", 32'(mmu_addrValid), 32'(!mis));
    if (!mis) chk("mmu_vAddr", mmu_vAddr, va);

    tick;  // accept+1
    req_valid = 1'b0;
    req_vaddr = $urandom;
    mmu_pAddr = xlate(va);
    mmu_db_io = va[28];
    mmu_exception = exc;
    bus_ack = early_ack;   // ack outside BUS must be ignored
    if (mis) begin
      chk("mis_valid", 32'(resp_valid), 32'd1);
      chk("mis_flag", 32'(resp_misalign), 32'd1);
      chk("mis_exc", 32'(resp_exc), 32'(`MMU_EXCEPTION_NONE));
      chk("mis_busreq", 32'(bus_req), 32'd0);
      tick;
      bus_ack = 1'b0;
      chk("mis_pulse", 32'(resp_valid), 32'd0);
      junk();
      return;
    end
    chk("xl_valid", 32'(resp_valid), 32'd0);
    chk("xl_busreq", 32'(bus_req), 32'd0);

    tick;  // accept+2
    junk();
    bus_ack = 1'b0;
    if (exc != `MMU_EXCEPTION_NONE) begin
      chk("exc_valid", 32'(resp_valid), 32'd1);
      chk("exc_code", 32'(resp_exc), 32'(exc));
      chk("exc_busreq", 32'(bus_req), 32'd0);
      tick;
      chk("exc_pulse", 32'(resp_valid), 32'd0);
      chk("exc_busreq2", 32'(bus_req), 32'd0);
      return;
    end
    chk("bus_req", 32'(bus_req), 32'd1);
    chk("bus_addr", bus_addr, {va[31:2], 2'b00} & 32'h1FFF_FFFC);
    chk("bus_be", 32'(bus_be), 32'(e_be));
    chk("bus_we", 32'(bus_we), 32'(we));
    chk("bus_io", 32'(bus_io), 32'(va[28]));
    if (we) chk("bus_wdata", bus_wdata, e_wd);
    chk("bus_early_valid", 32'(resp_valid), 32'd0);

    for (int w = 0; w < waitc; w++) begin
      tick;
      chk("bus_hold_req", 32'(bus_req), 32'd1);
      chk("bus_hold_be", 32'(bus_be), 32'(e_be));
    end
    bus_ack   = 1'b1;
    bus_rdata = rd;
    tick;  // response cycle
    bus_ack = 1'b0;
    junk();
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, e_rd);
    chk("resp_exc", 32'(resp_exc), 32'(`MMU_EXCEPTION_NONE));
    chk("resp_misalign", 32'(resp_misalign), 32'd0);
    chk("resp_buserr", 32'(resp_buserr), 32'd0);
    chk("resp_busreq", 32'(bus_req), 32'd0);
    tick;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("ready_again", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int maxw;
`ifdef BUS_TIMEOUT_EN
    maxw = 3;   // ack on the expiry cycle still completes normally
`else
    maxw = 5;
`endif
    res = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_type = '0; req_size = '0;
    req_wdata = '0; bus_ack = 1'b0;
    junk();
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_resp_exc", 32'(resp_exc), 32'(`MMU_EXCEPTION_NONE));
    chk("rst_addrValid", 32'(mmu_addrValid), 32'd0);
    chk("rst_buserr", 32'(resp_buserr), 32'd0);
    @(negedge clk);
    res = 1'b1;
    tick;

    // directed cases
    do_txn(32'h8000_1004, 1'b0, 2'd2, 32'h0, `MMU_EXCEPTION_NONE, 2, 32'hDEAD_BEEF, 1'b0);
    do_txn(32'h0000_2003, 1'b1, 2'd0, 32'h0000_00A5, `MMU_EXCEPTION_NONE, 0, 32'h0, 1'b0);
    do_txn(32'h0000_3002, 1'b0, 2'd1, 32'h0, `MMU_EXCEPTION_NONE, 1, 32'h1234_ABCD, 1'b0);
    do_txn(32'h0000_4000, 1'b0, 2'd2, 32'h0, `MMU_EXCEPTION_TLBMISS, 0, 32'h0, 1'b0);
    do_txn(32'h0000_5002, 1'b0, 2'd2, 32'h0, `MMU_EXCEPTION_NONE, 0, 32'h0, 1'b0);
    do_txn(32'h1000_6001, 1'b1, 2'd3, 32'hCAFE_F00D, `MMU_EXCEPTION_NONE, 0, 32'h0, 1'b0);
    do_txn(32'h1000_7000, 1'b0, 2'd3, 32'h0, `MMU_EXCEPTION_NONE, 0, 32'h0BAD_CAFE, 1'b1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] va;
      logic [2:0]  exc;
      va = $urandom;
      if ($urandom_range(0, 3) != 0) va[1:0] = va[1:0] & 2'($urandom);
      exc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : `MMU_EXCEPTION_NONE;
      do_txn(va, 1'($urandom), 2'($urandom), $urandom, exc,
             $urandom_range(0, maxw), $urandom, 1'($urandom));
    end

    // reset while the bus request is outstanding
    req_valid = 1'b1; req_vaddr = 32'h0000_8000; req_type = 2'd0; req_size = 2'd2;
    tick;
    req_valid = 1'b0;
    mmu_pAddr = 32'h0000_8000; mmu_db_io = 1'b0; mmu_exception = `MMU_EXCEPTION_NONE;
    tick;
    junk();
    chk("rstmid_busreq_pre", 32'(bus_req), 32'd1);
    #2 res = 1'b0;
    #1;
    chk("rstmid_busreq", 32'(bus_req), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    bus_ack = 1'b1;
    tick;
    chk("rstmid_novalid", 32'(resp_valid), 32'd0);
    bus_ack = 1'b0;
    @(negedge clk);
    res = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rstmid_quiet", 32'(resp_valid), 32'd0);
    end
    chk("rstmid_ready2", 32'(req_ready), 32'd1);

`ifdef BUS_TIMEOUT_EN
    begin
      int cyc;
      req_valid = 1'b1; req_vaddr = 32'h0000_9004; req_type = 2'd0; req_size = 2'd2;
      tick;
      req_valid = 1'b0;
      mmu_pAddr = 32'h0000_9004; mmu_db_io = 1'b0; mmu_exception = `MMU_EXCEPTION_NONE;
      tick;
      junk();
      bus_ack = 1'b0;
      cyc = 0;
      while (bus_req === 1'b1 && cyc < 20) begin
        tick;
        cyc++;
      end
      chk("tmo_len", 32'(cyc), 32'd4);
      chk("tmo_valid", 32'(resp_valid), 32'd1);
      chk("tmo_buserr", 32'(resp_buserr), 32'd1);
      chk("tmo_rdata", resp_rdata, 32'd0);
      tick;
      chk("tmo_pulse", 32'(resp_valid), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
